// File: rtl/sr_pulse_sequencer_if.sv
// Button inputs and latch-drive outputs of the SR pulse sequencer.
// The master side drives the buttons; the slave side is the sequencer itself.
interface sr_pulse_sequencer_if;
  logic       set_btn;
  logic       clr_btn;
  logic       S_bar;
  logic       R_bar;
  logic       busy;
  logic [7:0] drop_cnt;

  modport master (
    output set_btn, clr_btn,
    input  S_bar, R_bar, busy, drop_cnt
  );

  modport slave (
    input  set_btn, clr_btn,
    output S_bar, R_bar, busy, drop_cnt
  );
endinterface

// File: rtl/sr_pulse_sequencer.sv
// Synchronizes and debounces set/clear buttons and issues interlocked active-low S_bar/R_bar pulses.
// Define SR_PENDING_EN to add a one-deep buffer for requests that arrive while busy.
module sr_pulse_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 3,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input logic                 clk,
  input logic                 rst,
  sr_pulse_sequencer_if.slave bus
);
  localparam int unsigned PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] P_LAST  = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] G_LAST  = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SET_PULSE   = 2'd1,
    ST_RESET_PULSE = 2'd2,
    ST_GAP         = 2'd3
  } state_e;

`ifdef SR_PENDING_EN
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_SET  = 2'd1,
    PEND_CLR  = 2'd2
  } pend_e;

  pend_e pend_q, pend_d;
`endif

  // Bit 0 carries the set path, bit 1 the clear path.
  logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]      level_q, level_d, level_dly_q, level_dly_d, req_q, req_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  state_e          state_q, state_d;
  logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
  logic            s_bar_q, s_bar_d, r_bar_q, r_bar_d, busy_q, busy_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [8:0]      drop_sum_s;
  logic [1:0]      drop_inc_s;
  logic            done_s, set_req_s, clr_req_s;

  // Synchronizer, debounce counters and rising-edge request detection.
  always_comb begin
    sync1_d     = {bus.clr_btn, bus.set_btn};
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    req_d       = level_q & ~level_dly_q;
    level_d     = level_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        level_d[i]  = ~level_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Pulse FSM next state, drop accounting and next-state output decode.
  always_comb begin
    set_req_s  = req_q[0];
    clr_req_s  = req_q[1];
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    drop_inc_s = 2'd0;
    done_s     = 1'b0;
`ifdef SR_PENDING_EN
    pend_d     = pend_q;
`endif
    if (state_q != ST_IDLE) begin
`ifdef SR_PENDING_EN
      // A clear replaces a buffered set; a set never displaces anything.
      if (clr_req_s && (pend_q == PEND_CLR)) begin
        drop_inc_s = 2'd1;
      end else if (clr_req_s) begin
        pend_d = PEND_CLR;
      end else begin
        pend_d = pend_q;
      end
      if (set_req_s && (pend_d != PEND_NONE)) begin
        drop_inc_s = drop_inc_s + 2'd1;
      end else if (set_req_s) begin
        pend_d = PEND_SET;
      end else begin
        drop_inc_s = drop_inc_s;
      end
`else
      drop_inc_s = {1'b0, set_req_s} + {1'b0, clr_req_s};
`endif
    end else begin
      drop_inc_s = {1'b0, set_req_s & clr_req_s};
    end

    case (state_q)
      ST_IDLE: begin
        if (clr_req_s) begin
          state_d  = ST_RESET_PULSE;
          ph_cnt_d = '0;
        end else if (set_req_s) begin
          state_d  = ST_SET_PULSE;
          ph_cnt_d = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SET_PULSE, ST_RESET_PULSE: begin
        if (ph_cnt_q == P_LAST) begin
          if (GAP_CYCLES > 0) begin
            state_d  = ST_GAP;
            ph_cnt_d = '0;
          end else begin
            done_s   = 1'b1;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (ph_cnt_q == G_LAST) begin
          done_s   = 1'b1;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ph_cnt_d = '0;
      end
    endcase

    if (done_s) begin
      ph_cnt_d = '0;
`ifdef SR_PENDING_EN
      if (pend_d == PEND_CLR) begin
        state_d = ST_RESET_PULSE;
      end else if (pend_d == PEND_SET) begin
        state_d = ST_SET_PULSE;
      end else begin
        state_d = ST_IDLE;
      end
      pend_d = PEND_NONE;
`else
      state_d = ST_IDLE;
`endif
    end else begin
      state_d = state_d;
    end

    s_bar_d    = (state_d != ST_SET_PULSE);
    r_bar_d    = (state_d != ST_RESET_PULSE);
    busy_d     = (state_d != ST_IDLE);
    drop_sum_s = {1'b0, drop_cnt_q} + {7'd0, drop_inc_s};
    drop_cnt_d = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
  end

  // All state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      level_q     <= 2'b00;
      level_dly_q <= 2'b00;
      req_q       <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q     <= ST_IDLE;
      ph_cnt_q    <= '0;
      s_bar_q     <= 1'b1;
      r_bar_q     <= 1'b1;
      busy_q      <= 1'b0;
      drop_cnt_q  <= 8'd0;
`ifdef SR_PENDING_EN
      pend_q      <= PEND_NONE;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      req_q       <= req_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      s_bar_q     <= s_bar_d;
      r_bar_q     <= r_bar_d;
      busy_q      <= busy_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef SR_PENDING_EN
      pend_q      <= pend_d;
`endif
    end
  end

  assign bus.S_bar    = s_bar_q;
  assign bus.R_bar    = r_bar_q;
  assign bus.busy     = busy_q;
  assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Bench for sr_pulse_sequencer: directed scenarios plus random button traffic
// compared cycle by cycle against a countdown-based behavioural model.
module tb_sr_pulse_sequencer;
  localparam int D = 4;
  localparam int P = 3;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   inv_en = 1'b0;

  // Model: per-button pipeline as ints, scheduler as a countdown over pulse+gap.
  int m_s1[2], m_s2[2], m_lvl[2], m_prev[2], m_req[2], m_run[2];
  int m_rem = 0, m_kind = 0, m_pend = 0, m_drop = 0;

  sr_pulse_sequencer_if bus ();

  sr_pulse_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
    .GAP_CYCLES     (G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inv_en) begin
      n_cmp++;
      if ((bus.S_bar | bus.R_bar) !== 1'b1) begin
        n_err++;
        $display("FAIL invariant: S_bar=%b R_bar=%b, required at least one high", bus.S_bar, bus.R_bar);
      end
    end
  end

  function automatic logic exp_s();
    return (m_rem > G && m_kind == 1) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_r();
    return (m_rem > G && m_kind == 2) ? 1'b0 : 1'b1;
  endfunction

  task automatic step();
    int inb[2];
    int sr, cr;
    @(posedge clk);
    inb[0] = (bus.set_btn === 1'b1) ? 1 : 0;
    inb[1] = (bus.clr_btn === 1'b1) ? 1 : 0;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_prev[i] = 0; m_req[i] = 0; m_run[i] = 0;
      end
      m_rem = 0; m_kind = 0; m_pend = 0; m_drop = 0;
    end else begin
      sr = m_req[0];
      cr = m_req[1];
      if (m_rem == 0) begin
        if (cr != 0) begin
          m_kind = 2; m_rem = P + G; m_drop += sr;
        end else if (sr != 0) begin
          m_kind = 1; m_rem = P + G;
        end
      end else begin
`ifdef SR_PENDING_EN
        if (cr != 0) begin
          if (m_pend == 2) m_drop++; else m_pend = 2;
        end
        if (sr != 0) begin
          if (m_pend != 0) m_drop++; else m_pend = 1;
        end
`else
        m_drop += sr + cr;
`endif
        m_rem--;
        if (m_rem == 0 && m_pend != 0) begin
          m_kind = m_pend; m_rem = P + G; m_pend = 0;
        end
      end
      if (m_drop > 255) m_drop = 255;
      for (int i = 0; i < 2; i++) begin
        m_req[i]  = (m_lvl[i] == 1 && m_prev[i] == 0) ? 1 : 0;
        m_prev[i] = m_lvl[i];
        if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
        else if (m_run[i] + 1 == D) begin m_lvl[i] = 1 - m_lvl[i]; m_run[i] = 0; end
        else m_run[i]++;
        m_s2[i] = m_s1[i];
        m_s1[i] = inb[i];
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.set_btn = 1'b0; bus.clr_btn = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.set_btn = 1'($urandom_range(0, 1));
      bus.clr_btn = 1'($urandom_range(0, 1));
      step();
      inv_en = 1'b1;
      n_cmp += 4;
      if (bus.S_bar !== 1'b1) begin n_err++; $display("FAIL reset_s_bar: got %b, required 1", bus.S_bar); end
      if (bus.R_bar !== 1'b1) begin n_err++; $display("FAIL reset_r_bar: got %b, required 1", bus.R_bar); end
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
      if (bus.drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d, required 0", bus.drop_cnt); end
    end
    rst = 1'b0; bus.set_btn = 1'b0; bus.clr_btn = 1'b0;
    repeat (D + 4) step();
  endtask

  task automatic test_clean_set();
    do_reset();
    bus.set_btn = 1'b1;
    for (int k = 0; k < 28; k++) begin
      if (k == 20) bus.set_btn = 1'b0;
      step();
      n_cmp += 3;
      if (bus.S_bar !== ((k >= 7 && k <= 9) ? 1'b0 : 1'b1)) begin
        n_err++; $display("FAIL clean_set_s_bar E+%0d: got %b, required %b", k, bus.S_bar, (k >= 7 && k <= 9) ? 1'b0 : 1'b1);
      end
      if (bus.R_bar !== 1'b1) begin n_err++; $display("FAIL clean_set_r_bar E+%0d: got %b, required 1", k, bus.R_bar); end
      if (bus.busy !== ((k >= 7 && k <= 11) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL clean_set_busy E+%0d: got %b, required %b", k, bus.busy, (k >= 7 && k <= 11) ? 1'b1 : 1'b0);
      end
    end
    n_cmp++;
    if (bus.drop_cnt !== 8'd0) begin n_err++; $display("FAIL clean_set_drop: got %0d, required 0", bus.drop_cnt); end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    bus.set_btn = 1'b1;
    repeat (8) step();
    n_cmp++;
    if (bus.S_bar !== 1'b0) begin n_err++; $display("FAIL mid_pulse_start: got %b, required 0", bus.S_bar); end
    rst = 1'b1;
    step();
    n_cmp += 2;
    if (bus.S_bar !== 1'b1) begin n_err++; $display("FAIL mid_pulse_abort_s: got %b, required 1", bus.S_bar); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_pulse_abort_busy: got %b, required 0", bus.busy); end
    bus.set_btn = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset();
    bus.set_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) bus.set_btn = 1'b0;
      step();
      n_cmp += 2;
      if (bus.S_bar !== 1'b1) begin n_err++; $display("FAIL glitch_s_bar E+%0d: got %b, required 1", k, bus.S_bar); end
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy E+%0d: got %b, required 0", k, bus.busy); end
    end
    n_cmp++;
    if (bus.drop_cnt !== 8'd0) begin n_err++; $display("FAIL glitch_drop: got %0d, required 0", bus.drop_cnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.set_btn = 1'b1; bus.clr_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp += 2;
      if (bus.R_bar !== ((k >= 7 && k <= 9) ? 1'b0 : 1'b1)) begin
        n_err++; $display("FAIL simul_r_bar E+%0d: got %b, required %b", k, bus.R_bar, (k >= 7 && k <= 9) ? 1'b0 : 1'b1);
      end
      if (bus.S_bar !== 1'b1) begin n_err++; $display("FAIL simul_s_bar E+%0d: got %b, required 1", k, bus.S_bar); end
    end
    n_cmp++;
    if (bus.drop_cnt !== 8'd1) begin n_err++; $display("FAIL simul_drop: got %0d, required 1", bus.drop_cnt); end
    bus.set_btn = 1'b0; bus.clr_btn = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_busy_request();
    logic r_exp;
    do_reset();
    bus.set_btn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 1) bus.clr_btn = 1'b1;
      step();
`ifdef SR_PENDING_EN
      r_exp = (k >= 12 && k <= 14) ? 1'b0 : 1'b1;
`else
      r_exp = 1'b1;
`endif
      n_cmp += 2;
      if (bus.S_bar !== ((k >= 7 && k <= 9) ? 1'b0 : 1'b1)) begin
        n_err++; $display("FAIL busy_req_s_bar E+%0d: got %b, required %b", k, bus.S_bar, (k >= 7 && k <= 9) ? 1'b0 : 1'b1);
      end
      if (bus.R_bar !== r_exp) begin n_err++; $display("FAIL busy_req_r_bar E+%0d: got %b, required %b", k, bus.R_bar, r_exp); end
    end
    n_cmp++;
`ifdef SR_PENDING_EN
    if (bus.drop_cnt !== 8'd0) begin n_err++; $display("FAIL busy_req_drop: got %0d, required 0", bus.drop_cnt); end
`else
    if (bus.drop_cnt !== 8'd1) begin n_err++; $display("FAIL busy_req_drop: got %0d, required 1", bus.drop_cnt); end
`endif
    bus.set_btn = 1'b0; bus.clr_btn = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_random();
    int hold_s = 0, hold_c = 0;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (hold_s == 0) begin bus.set_btn = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 10); end
      if (hold_c == 0) begin bus.clr_btn = 1'($urandom_range(0, 1)); hold_c = $urandom_range(1, 10); end
      hold_s--; hold_c--;
      rst = ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0;
      step();
      n_cmp += 4;
      if (bus.S_bar !== exp_s()) begin n_err++; $display("FAIL random_s_bar cyc %0d: got %b, required %b", n, bus.S_bar, exp_s()); end
      if (bus.R_bar !== exp_r()) begin n_err++; $display("FAIL random_r_bar cyc %0d: got %b, required %b", n, bus.R_bar, exp_r()); end
      if (bus.busy !== (m_rem > 0)) begin n_err++; $display("FAIL random_busy cyc %0d: got %b, required %b", n, bus.busy, m_rem > 0); end
      if (bus.drop_cnt !== 8'(m_drop)) begin n_err++; $display("FAIL random_drop cyc %0d: got %0d, required %0d", n, bus.drop_cnt, m_drop); end
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    int hold;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      for (int ph = 0; ph < 2; ph++) begin
        bus.set_btn = (ph == 0) ? 1'b1 : 1'b0;
        bus.clr_btn = bus.set_btn;
        hold = $urandom_range(9, 12);
        for (int c = 0; c < hold; c++) begin
          step();
          n_cmp += 3;
          if (bus.S_bar !== exp_s()) begin n_err++; $display("FAIL sat_s_bar it %0d: got %b, required %b", it, bus.S_bar, exp_s()); end
          if (bus.R_bar !== exp_r()) begin n_err++; $display("FAIL sat_r_bar it %0d: got %b, required %b", it, bus.R_bar, exp_r()); end
          if (bus.drop_cnt !== 8'(m_drop)) begin n_err++; $display("FAIL sat_drop it %0d: got %0d, required %0d", it, bus.drop_cnt, m_drop); end
        end
      end
    end
    n_cmp++;
    if (bus.drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_final: got %0d, required 255", bus.drop_cnt); end
  endtask

  initial begin
    bus.set_btn = 1'b0;
    bus.clr_btn = 1'b0;
    test_reset();
    test_clean_set();
    test_reset_mid_pulse();
    test_glitch();
    test_simultaneous();
    test_busy_request();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sr_pulse_sequencer.md
Name: sr_pulse_sequencer

Overview:
Upstream driver for the NAND SR latch. It takes two raw push-button inputs (set, clear) and synchronizes and debounces each one. It then converts debounced rising edges into fixed-width active-low S_bar/R_bar pulses. An interlock guarantees S_bar and R_bar are never low in the same cycle, so the latch never sees the forbidden 0/0 input.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=1)
PULSE_CYCLES, 3, cycles S_bar or R_bar is held low per request (>=1)
GAP_CYCLES, 2, cycles with both outputs high after each pulse before the next request is accepted (>=0)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
set_btn  input  1  raw asynchronous set button, active-high
clr_btn  input  1  raw asynchronous clear button, active-high
S_bar  output  1  active-low set drive to latch, registered
R_bar  output  1  active-low reset drive to latch, registered
busy  output  1  high while in SET_PULSE, RESET_PULSE or GAP
drop_cnt  output  8  count of discarded requests, saturating at 255

Behaviour:
- Reset (rst=1 at clk edge): S_bar=1, R_bar=1, busy=0, drop_cnt=0, FSM=IDLE. All synchronizer flops, debounced levels, edge registers and counters are cleared to 0. Reset mid-pulse aborts the pulse at the next edge.
- Synchronizer: two flops per button.
- Debounce, per button:
  - Counter clears whenever the synced value equals the debounced level.
  - While they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips at that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
- Edge detect: a registered rising edge of each debounced level gives one-cycle set_req / clr_req.
- FSM states and transitions:
  - IDLE: clr_req -> RESET_PULSE. Else set_req -> SET_PULSE.
  - SET_PULSE: S_bar=0, R_bar=1 for exactly PULSE_CYCLES cycles. Then GAP, or IDLE if GAP_CYCLES=0.
  - RESET_PULSE: R_bar=0, S_bar=1 for PULSE_CYCLES cycles. Then GAP or IDLE, as above.
  - GAP: both high for GAP_CYCLES cycles. Then IDLE.
- Outputs are decoded from the next state and registered. S_bar falls on the same edge the FSM enters SET_PULSE.
- Latency: raw set_btn rising with clean setup before edge E gives S_bar low from edge E+DEBOUNCE_CYCLES+3.
- Simultaneous set_req and clr_req in IDLE: clear wins. The set request is discarded and drop_cnt increments.
- Request arriving while busy: discarded and drop_cnt increments, unless SR_PENDING_EN is defined.
- drop_cnt holds at 255 and does not wrap.
- Invariant: S_bar|R_bar==1 in every cycle, including cycles with reset.
- Button release (falling debounced edge) produces no action.

Optional Feature:
Macro SR_PENDING_EN.
- Defined: adds a one-deep pending buffer. A request arriving while busy is stored (clear overwrites a stored set; a set does not overwrite a stored clear). The stored request is issued on the cycle the FSM would return to IDLE, going directly to the pulse state with no IDLE cycle. A further request while the buffer is full is dropped and counted. Simultaneous set/clear in IDLE still drops the set. The buffer is cleared by rst.
- Undefined: no buffer. All busy-time requests are dropped and counted.

Test Plan:
All scenarios use default parameters unless stated.
- Reset: hold rst 3 cycles with buttons toggling -> S_bar=1, R_bar=1, busy=0, drop_cnt=0 throughout.
- Clean set: set_btn high 20 cycles from edge E -> S_bar=0 at edges E+7..E+9. Both outputs high from E+10. busy=0 from E+12.
- Glitch rejection: set_btn high 3 cycles then low -> S_bar never low, drop_cnt=0.
- Simultaneous press: set_btn and clr_btn rise together and are held -> R_bar low 3 cycles, S_bar stays 1, drop_cnt=1.
- Busy request: clr_btn pressed so its req lands during a set pulse.
  - Without SR_PENDING_EN: no R_bar pulse, drop_cnt=1.
  - With SR_PENDING_EN: R_bar goes low on the first edge after GAP ends, drop_cnt=0.
- Saturation plus invariant: 300 forced-drop events -> drop_cnt=255. Checker asserts S_bar|R_bar every cycle.
